// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with flush and stall counter
//
// Build option: define PIPE_STAGE_SKID_EN to add a skid entry and register in_ready.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - synchronous active-high reset
//   flush      - discard all held entries at this edge
//   in_valid   - upstream payload valid
//   in_ready   - stage accepts in_data this cycle
//   in_data    - upstream payload
//   out_valid  - out_data holds a live entry
//   out_ready  - downstream accepts out_data this cycle
//   out_data   - registered payload
//   stall_cnt  - saturating count of edges with out_valid=1 and out_ready=0

module pipe_stage_reg #(
    parameter int               WIDTH     = 171,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             main_valid;
    logic [WIDTH-1:0] main_data;
    logic             main_valid_d;
    logic [WIDTH-1:0] main_data_d;
    logic             in_xfer;

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign in_xfer   = in_valid && in_ready;

`ifdef PIPE_STAGE_SKID_EN

    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             skid_valid_d;
    logic [WIDTH-1:0] skid_data_d;
    logic             ready_q;

    // in_ready comes straight from a flop: it only advertises whether the
    // skid entry is free, so out_ready never reaches it combinationally.
    assign in_ready = ready_q;

    always_comb begin
        main_valid_d = main_valid;
        main_data_d  = main_data;
        skid_valid_d = skid_valid;
        skid_data_d  = skid_data;
        if (flush) begin
            main_valid_d = 1'b0;
            main_data_d  = RESET_VAL;
            skid_valid_d = 1'b0;
        end else if (!main_valid || out_ready) begin
            // Main is empty or draining: the skid entry is older than any
            // new input, so it moves up first. in_ready is low whenever the
            // skid is full, so no input can arrive in that case.
            if (skid_valid) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data;
                skid_valid_d = 1'b0;
            end else if (in_xfer) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            // Main is held by backpressure: park the new entry behind it.
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_data  <= RESET_VAL;
            skid_valid <= 1'b0;
            skid_data  <= RESET_VAL;
            ready_q    <= 1'b1;
        end else begin
            main_valid <= main_valid_d;
            main_data  <= main_data_d;
            skid_valid <= skid_valid_d;
            skid_data  <= skid_data_d;
            ready_q    <= !skid_valid_d;
        end
    end

`else

    // Single entry: accept when empty or when the current entry leaves now.
    assign in_ready = !main_valid || out_ready;

    always_comb begin
        main_valid_d = main_valid;
        main_data_d  = main_data;
        if (flush) begin
            main_valid_d = 1'b0;
            main_data_d  = RESET_VAL;
        end else if (in_ready) begin
            // With no new input the entry just drains; its data is kept
            // so out_data holds the last value while out_valid is low.
            main_valid_d = in_valid;
            if (in_valid) begin
                main_data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_data  <= RESET_VAL;
        end else begin
            main_valid <= main_valid_d;
            main_data  <= main_data_d;
        end
    end

`endif

    // Flush does not clear the counter; it only suppresses counting on the
    // flushing edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (main_valid && !out_ready && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 171: payload width in bits.
REQ-002 Parameter RESET_VAL, default {WIDTH{1'b0}}: payload value after reset or flush.
REQ-003 Parameter CNT_W, default 16: stall counter width.
REQ-004 Port clk  input  1: single clock, all state updates on posedge clk.
REQ-005 Port rst  input  1: synchronous, active-high reset.
REQ-006 Port flush  input  1: kill the stage contents; sampled on posedge clk.
REQ-007 Port in_valid  input  1: upstream payload valid.
REQ-008 Port in_ready  output  1: stage can accept in_data this cycle.
REQ-009 Port in_data  input  WIDTH: upstream payload (packed stage fields).
REQ-010 Port out_valid  output  1: out_data holds a live entry.
REQ-011 Port out_ready  input  1: downstream accepts out_data this cycle.
REQ-012 Port out_data  output  WIDTH: registered payload.
REQ-013 Port stall_cnt  output  CNT_W: cycles with out_valid=1 and out_ready=0.
REQ-014 The block SHALL use one clock, clk; rst SHALL be synchronous and active-high.

Function
REQ-015 An input transfer SHALL occur when in_valid=1 and in_ready=1 at a posedge; an output transfer when out_valid=1 and out_ready=1.
REQ-016 Latency SHALL be 1 cycle: an accepted entry SHALL appear on out_data/out_valid after the accepting edge, provided the stage was empty or draining.
REQ-017 Entries SHALL leave in acceptance order; no entry SHALL be dropped or duplicated except by flush.
REQ-018 While out_valid=1 and out_ready=0, out_data and out_valid SHALL hold stable.
REQ-019 When out_valid=0, out_data SHALL hold its last value (RESET_VAL after reset/flush).
REQ-020 Simultaneous input and output transfer SHALL replace the entry with no bubble, sustaining 1 entry/cycle.
REQ-021 flush=1 SHALL clear all entries (out_valid=0, out_data=RESET_VAL) at that edge; flush SHALL take priority over any same-cycle input transfer, whose data is discarded.
REQ-022 in_ready SHALL not depend on flush.
REQ-023 stall_cnt SHALL increment by 1 on each edge where out_valid=1 and out_ready=0 and flush=0, saturating at all ones; it SHALL not clear on flush.
REQ-024 stall_cnt SHALL be unsigned CNT_W bits, no wrap-around.

Reset
REQ-025 On rst=1 at a posedge: out_valid=0, out_data=RESET_VAL, stall_cnt=0, all internal entries empty; rst SHALL override flush and all transfers.
REQ-026 In the cycle after reset deassertion in_ready SHALL be 1.
REQ-027 Reset mid-stall SHALL discard held and buffered entries without an output transfer.

Configuration
REQ-028 Macro PIPE_STAGE_SKID_EN SHALL select the ready-path structure.
REQ-029 Without PIPE_STAGE_SKID_EN: single entry; in_ready = !out_valid || out_ready (combinational from out_ready).
REQ-030 With PIPE_STAGE_SKID_EN: main entry plus one skid entry; in_ready SHALL be a registered signal equal to "skid entry empty", with no combinational path from out_ready.
REQ-031 With skid: an input accepted while main is held (out_ready=0) SHALL go to the skid entry; when main drains, skid SHALL move to main on the same edge, and in_ready SHALL return to 1 the following cycle.
REQ-032 With skid: flush SHALL clear both entries; throughput, ordering and latency per REQ-016..020 SHALL be unchanged.

Verification
REQ-033 Reset: rst=1 two cycles with in_valid=1, in_data=0x5A -> out_valid=0, out_data=RESET_VAL, stall_cnt=0, in_ready=1 after release.
REQ-034 Streaming: in_valid=1, out_ready=1, data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later each, out_valid continuously 1.
REQ-035 Backpressure: load 0xA, out_ready=0 for 5 cycles while in_valid=1 with 0xB -> out_data holds 0xA, stall_cnt=5; no-skid: in_ready=0; skid: 0xB captured, in_ready=0 after; release -> 0xA then 0xB, no loss.
REQ-036 Flush priority: flush=1 with in_valid=1, in_data=0xC, stage holding 0xA -> next cycle out_valid=0, out_data=RESET_VAL, 0xC never emitted.
REQ-037 Saturation: CNT_W=4, hold out_ready=0 with out_valid=1 for 20 cycles -> stall_cnt=15 and stays 15.
REQ-038 Both macro settings SHALL pass REQ-033..037 against a reference FIFO scoreboard with random in_valid/out_ready/flush.
